// File: rtl/addsub_seq.sv
// rtl/addsub_seq.sv - byte-serial multi-byte add/subtract sequencer with an internal 8-bit adder.
// Processes one byte per RUN cycle, LSB first, chaining the carry; flags are registered at the last byte.
module addsub_seq #(
  parameter int NBYTES = 4,
  localparam int W = 8 * NBYTES
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic [1:0]   OP,
  input  logic         CIN,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] RESULT,
  output logic         COUT,
  output logic         OVF,
  output logic         ZERO,
  output logic         CISEL,
  output logic         BSEL
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [1:0]    op_q, op_d;
  logic          cin_q, cin_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  result_q, result_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          zero_q, zero_d;

  logic [7:0] a_k, b_k, b_x;
  logic       ci0, ci_k, c7;
  logic [8:0] sum9;

  // OP[0] selects subtract-style (invert B); OP[1] selects the carry/borrow-in variants.
  assign ci0  = op_q[1] ? (cin_q ^ op_q[0]) : op_q[0];
  assign ci_k = (idx_q == '0) ? ci0 : carry_q;
  assign a_k  = a_q[{idx_q, 3'b000} +: 8];
  assign b_k  = b_q[{idx_q, 3'b000} +: 8];
  assign b_x  = op_q[0] ? ~b_k : b_k;
  assign sum9 = {1'b0, a_k} + {1'b0, b_x} + {8'b0, ci_k};
  assign c7   = a_k[7] ^ b_x[7] ^ sum9[7];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cin_d    = cin_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          a_d      = A;
          b_d      = B;
          op_d     = OP;
          cin_d    = CIN;
          idx_d    = '0;
          carry_d  = 1'b0;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          zero_d   = 1'b0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        result_d[{idx_q, 3'b000} +: 8] = sum9[7:0];
        carry_d = sum9[8];
        if (idx_q == LAST_IDX) begin
          cout_d  = sum9[8] ^ op_q[0];
          ovf_d   = c7 ^ sum9[8];
          zero_d  = (result_d == '0);
          state_d = ST_FIN;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cin_q    <= 1'b0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cin_q    <= cin_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign BUSY   = (state_q == ST_RUN);
  assign DONE   = (state_q == ST_FIN);
  assign RESULT = result_q;
  assign COUT   = cout_q;
  assign OVF    = ovf_q;
  assign ZERO   = zero_q;
  assign CISEL  = (state_q == ST_RUN) & ci_k;
  assign BSEL   = (state_q == ST_RUN) & op_q[0];

endmodule

// File: tb/tb_addsub_seq.sv
// tb/tb_addsub_seq.sv - randomized and directed bench for addsub_seq (NBYTES=4).
module tb_addsub_seq;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         CLK = 1'b0;
  logic         RST_N, START, CIN;
  logic [1:0]   OP;
  logic [W-1:0] A, B;
  logic         BUSY, DONE, COUT, OVF, ZERO, CISEL, BSEL;
  logic [W-1:0] RESULT;

  int checks = 0;
  int errors = 0;

  // per-run capture
  logic [W-1:0] r_res;
  logic         r_cout, r_ovf, r_zero;
  int           r_done_k, r_busy_n, r_done_n;
  logic [NB-1:0] r_cisel, r_bsel;

  addsub_seq #(.NBYTES(NB)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .OP(OP), .CIN(CIN), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .COUT(COUT), .OVF(OVF), .ZERO(ZERO),
    .CISEL(CISEL), .BSEL(BSEL)
  );

  always #5 CLK = ~CLK;

  // Reference: whole-word integer arithmetic, no byte chaining.
  function automatic void model(input logic [1:0] op, input logic cin, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] r,
                                output logic c, output logic o, output logic z);
    logic [W:0] u;
    longint sa, sb, s, ci;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ci = op[1] ? longint'(cin) : 0;
    if (!op[0]) begin
      u = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
      c = u[W];
      s = sa + sb + ci;
    end else begin
      u = {1'b0, a} - {1'b0, b} - (W+1)'(ci);
      c = ({1'b0, a} < ({1'b0, b} + (W+1)'(ci)));
      s = sa - sb - ci;
    end
    r = u[W-1:0];
    o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    z = (r == '0);
  endfunction

  // Drives one operation and records observations; inject pulses START in RUN and FIN.
  task automatic run_op(input logic [1:0] op, input logic cin, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit inject);
    @(negedge CLK);
    START = 1'b1; OP = op; CIN = cin; A = a; B = b;
    r_done_k = -1; r_busy_n = 0; r_cisel = '0; r_bsel = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      START = 1'b0;
      OP = 2'($urandom); CIN = 1'($urandom); A = $urandom; B = $urandom;
      if (inject && k == 1) START = 1'b1;
      if (BUSY) begin
        if (k < NB) begin
          r_cisel[k] = CISEL;
          r_bsel[k]  = BSEL;
        end
        r_busy_n++;
      end
      if (DONE) begin
        r_done_k = k;
        r_res = RESULT; r_cout = COUT; r_ovf = OVF; r_zero = ZERO;
        if (inject) START = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b0; START = 1'b0; OP = '0; CIN = 1'b0; A = '0; B = '0;
    #12;
    checks++;
    if ({BUSY, DONE, COUT, OVF, ZERO, CISEL, BSEL} !== 7'b0 || RESULT !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b res=%h cout=%b ovf=%b zero=%b cisel=%b bsel=%b want all 0",
               BUSY, DONE, RESULT, COUT, OVF, ZERO, CISEL, BSEL);
    end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_directed;
    logic [1:0]   ops [7]  = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic         cins[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] as  [7]  = '{32'h000000FF, 32'h0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd5, 32'd9};
    logic [W-1:0] bs  [7]  = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h0, 32'd3, 32'd7};
    logic [W-1:0] er  [7]  = '{32'h00000100, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h0, 32'd1, 32'd16};
    logic         ec  [7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic         eo  [7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic         ez  [7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], cins[i], as[i], bs[i], 1'b0);
      checks++;
      if (r_done_k !== NB || r_busy_n !== NB) begin
        errors++;
        $display("FAIL dir%0d_latency: got done_k=%0d busy=%0d want %0d/%0d", i, r_done_k, r_busy_n, NB, NB);
      end
      checks++;
      if (r_res !== er[i] || r_cout !== ec[i] || r_ovf !== eo[i] || r_zero !== ez[i]) begin
        errors++;
        $display("FAIL dir%0d_result: got %h c=%b o=%b z=%b want %h c=%b o=%b z=%b",
                 i, r_res, r_cout, r_ovf, r_zero, er[i], ec[i], eo[i], ez[i]);
      end
      if (i == 0) begin
        checks++;
        if (r_cisel !== 4'b0010 || r_bsel !== 4'b0000) begin
          errors++;
          $display("FAIL add_cisel_seq: got cisel=%b bsel=%b want 0010/0000 (byte0 at bit0)", r_cisel, r_bsel);
        end
      end
      if (i == 1) begin
        checks++;
        if (r_cisel[0] !== 1'b1 || r_bsel !== 4'b1111) begin
          errors++;
          $display("FAIL sub_selects: got cisel0=%b bsel=%b want 1/1111", r_cisel[0], r_bsel);
        end
      end
    end
    // results hold in IDLE; selects idle low
    repeat (3) @(negedge CLK);
    checks++;
    if (RESULT !== 32'd16 || DONE !== 1'b0 || BUSY !== 1'b0 || CISEL !== 1'b0 || BSEL !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got res=%h done=%b busy=%b cisel=%b bsel=%b want 00000010/0/0/0/0",
               RESULT, DONE, BUSY, CISEL, BSEL);
    end
  endtask

  task automatic test_random;
    logic [1:0]   op;
    logic         cin, c, o, z;
    logic [W-1:0] a, b, r;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom); cin = 1'($urandom); a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? a : $urandom;
      model(op, cin, a, b, r, c, o, z);
      run_op(op, cin, a, b, 1'b0);
      checks++;
      if (r_done_k !== NB || r_res !== r || r_cout !== c || r_ovf !== o || r_zero !== z) begin
        errors++;
        $display("FAIL rand%0d op=%0d cin=%b a=%h b=%h: got k=%0d %h c=%b o=%b z=%b want k=%0d %h c=%b o=%b z=%b",
                 i, op, cin, a, b, r_done_k, r_res, r_cout, r_ovf, r_zero, NB, r, c, o, z);
      end
    end
  endtask

  task automatic test_start_ignored;
    int dones = 0;
    run_op(2'd0, 1'b0, 32'h11111111, 32'h22222222, 1'b1);
    checks++;
    if (r_done_k !== NB || r_res !== 32'h33333333) begin
      errors++;
      $display("FAIL start_in_run: got k=%0d res=%h want %0d 33333333", r_done_k, r_res, NB);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      START = 1'b0;
      if (DONE) dones++;
    end
    checks++;
    if (dones !== 0 || RESULT !== 32'h33333333) begin
      errors++;
      $display("FAIL start_in_fin: got extra_dones=%0d res=%h want 0 33333333", dones, RESULT);
    end
  endtask

  task automatic test_back_to_back;
    run_op(2'd1, 1'b0, 32'd100, 32'd1, 1'b0);
    run_op(2'd0, 1'b0, 32'd40, 32'd2, 1'b0);
    checks++;
    if (r_done_k !== NB || r_res !== 32'd42) begin
      errors++;
      $display("FAIL back_to_back: got k=%0d res=%0d want %0d 42", r_done_k, r_res, NB);
    end
  endtask

  task automatic test_reset_mid_run;
    int dones = 0;
    @(negedge CLK);
    START = 1'b1; OP = 2'd0; CIN = 1'b0; A = 32'h01010101; B = 32'h01010101;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (RESULT !== 32'h00000202 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL partial_result: got res=%h busy=%b want 00000202 1", RESULT, BUSY);
    end
    RST_N = 1'b0;
    #1;
    checks++;
    if (RESULT !== '0 || BUSY !== 1'b0 || DONE !== 1'b0 || CISEL !== 1'b0 || BSEL !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got res=%h busy=%b done=%b cisel=%b bsel=%b want all 0",
               RESULT, BUSY, DONE, CISEL, BSEL);
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL no_done_after_abort: got %0d want 0", dones);
    end
    run_op(2'd0, 1'b0, 32'd2, 32'd3, 1'b0);
    checks++;
    if (r_done_k !== NB || r_res !== 32'd5 || r_cout !== 1'b0 || r_zero !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_add: got k=%0d res=%0d c=%b z=%b want %0d 5 0 0", r_done_k, r_res, r_cout, r_zero, NB);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
